// File: rtl/parity_push_gen.sv
// ---------------------------------------------------------------------------
// parity_push_gen
//   Transmit-side parity generator for a FIFO push interface. Raw payload
//   words from a producer are parity-encoded on acceptance and staged in a
//   2-entry skid buffer (main + skid). This sustains one word per clock while
//   isolating the producer from FIFO back-pressure.
//
// Parameters
//   DATA_WIDTH : payload width; the pushed word is DATA_WIDTH+1 bits
//   EVEN_ODD   : 0 = even parity over the whole word, 1 = odd parity
//   PARITY_BIT : 0 = parity in bit 0, 1 = parity in bit DATA_WIDTH
//   CNT_WIDTH  : width of the wrapping sent-word counter(s)
//
// Ports
//   clk             : clock, rising edge
//   rst_n           : asynchronous active-low reset
//   in_data_i       : producer payload
//   in_valid_i      : producer has a word
//   in_grant_o      : block can accept a word (registered)
//   push_data_o     : encoded word to the FIFO (holds when not valid)
//   push_valid_o    : encoded word valid
//   push_grant_i    : FIFO can accept
//   tx_count_o      : words accepted by the FIFO, wrapping
//   err_inj_i       : (PARITY_ERR_INJ_EN) invert parity of the accepted word
//   err_inj_count_o : (PARITY_ERR_INJ_EN) number of corrupted words accepted
//
// Optional feature macro: PARITY_ERR_INJ_EN
// ---------------------------------------------------------------------------
module parity_push_gen #(
    parameter int DATA_WIDTH = 32,
    parameter int EVEN_ODD   = 0,
    parameter int PARITY_BIT = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  in_valid_i,
    output logic                  in_grant_o,
    output logic [DATA_WIDTH:0]   push_data_o,
    output logic                  push_valid_o,
    input  logic                  push_grant_i,
    output logic [CNT_WIDTH-1:0]  tx_count_o
`ifdef PARITY_ERR_INJ_EN
    ,
    input  logic                  err_inj_i,
    output logic [CNT_WIDTH-1:0]  err_inj_count_o
`endif
);

    localparam int W = DATA_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // Build the encoded word; flip inverts the parity bit for error injection.
    function automatic logic [W-1:0] encode_word(input logic [DATA_WIDTH-1:0] d,
                                                 input logic flip);
        logic p;
        p = (^d) ^ ((EVEN_ODD != 0) ? 1'b1 : 1'b0) ^ flip;
        if (PARITY_BIT == 0) begin
            encode_word = {d, p};
        end else begin
            encode_word = {p, d};
        end
    endfunction

    state_t               state_r;
    state_t               state_s;
    logic [W-1:0]         main_data_r;
    logic [W-1:0]         skid_data_r;
    logic                 push_valid_r;
    logic                 in_grant_r;
    logic [CNT_WIDTH-1:0] tx_count_r;
    logic                 in_acc_s;
    logic                 push_acc_s;
    logic                 inj_s;
    logic [W-1:0]         enc_s;
    logic                 load_main_s;
    logic                 main_from_skid_s;
    logic                 load_skid_s;

`ifdef PARITY_ERR_INJ_EN
    logic [CNT_WIDTH-1:0] err_cnt_r;
    assign inj_s           = err_inj_i;
    assign err_inj_count_o = err_cnt_r;
`else
    assign inj_s = 1'b0;
`endif

    assign in_acc_s   = in_valid_i & in_grant_r;
    assign push_acc_s = push_valid_r & push_grant_i;
    assign enc_s      = encode_word(in_data_i, inj_s);

    assign in_grant_o   = in_grant_r;
    assign push_valid_o = push_valid_r;
    assign push_data_o  = main_data_r;
    assign tx_count_o   = tx_count_r;

    // Next-state and buffer load control for the skid buffer.
    always_comb begin
        state_s          = state_r;
        load_main_s      = 1'b0;
        main_from_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (in_acc_s) begin
                    state_s     = ST_ONE;
                    load_main_s = 1'b1;
                end else begin
                    state_s = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (in_acc_s && push_acc_s) begin
                    state_s     = ST_ONE;
                    load_main_s = 1'b1;
                end else if (in_acc_s) begin
                    state_s     = ST_TWO;
                    load_skid_s = 1'b1;
                end else if (push_acc_s) begin
                    state_s = ST_EMPTY;
                end else begin
                    state_s = ST_ONE;
                end
            end
            ST_TWO: begin
                // Grant is low here, so only the output side can move.
                if (push_acc_s) begin
                    state_s          = ST_ONE;
                    load_main_s      = 1'b1;
                    main_from_skid_s = 1'b1;
                end else begin
                    state_s = ST_TWO;
                end
            end
            default: begin
                state_s = ST_EMPTY;
            end
        endcase
    end

    // State, registered handshake outputs and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_EMPTY;
            push_valid_r <= 1'b0;
            in_grant_r   <= 1'b0;
            tx_count_r   <= {CNT_WIDTH{1'b0}};
        end else begin
            state_r      <= state_s;
            push_valid_r <= (state_s != ST_EMPTY);
            in_grant_r   <= (state_s != ST_TWO);
            if (push_acc_s) begin
                tx_count_r <= tx_count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    // Encoded data registers; main drives push_data_o and holds when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_data_r <= {W{1'b0}};
            skid_data_r <= {W{1'b0}};
        end else begin
            if (load_main_s) begin
                main_data_r <= main_from_skid_s ? skid_data_r : enc_s;
            end
            if (load_skid_s) begin
                skid_data_r <= enc_s;
            end
        end
    end

`ifdef PARITY_ERR_INJ_EN
    // Count words accepted with their parity deliberately corrupted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (in_acc_s && err_inj_i) begin
            err_cnt_r <= err_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end
`endif

endmodule

// File: tb/tb_parity_push_gen.sv
// ---------------------------------------------------------------------------
// tb_parity_push_gen
//   Directed self-checking bench. Four instances share the input stimulus:
//   the default build, an odd-parity build, a parity-at-MSB build and a
//   4-bit-counter build. Inputs change 1 time unit after the rising edge and
//   outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_parity_push_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] in_data = 32'd0;
    logic        in_valid = 1'b0;
    logic        push_grant = 1'b0;
`ifdef PARITY_ERR_INJ_EN
    logic        err_inj = 1'b0;
    logic [15:0] err_cnt_a;
    logic [15:0] err_cnt_b;
    logic [15:0] err_cnt_c;
    logic [3:0]  err_cnt_d;
`endif

    logic        grant_a, grant_b, grant_c, grant_d;
    logic [32:0] data_a, data_b, data_c, data_d;
    logic        valid_a, valid_b, valid_c, valid_d;
    logic [15:0] cnt_a, cnt_b, cnt_c;
    logic [3:0]  cnt_d;

    int cmp_count  = 0;
    int fail_count = 0;

    always #5 clk = ~clk;

    parity_push_gen dut (
        .clk(clk), .rst_n(rst_n), .in_data_i(in_data), .in_valid_i(in_valid),
        .in_grant_o(grant_a), .push_data_o(data_a), .push_valid_o(valid_a),
        .push_grant_i(push_grant), .tx_count_o(cnt_a)
`ifdef PARITY_ERR_INJ_EN
        , .err_inj_i(err_inj), .err_inj_count_o(err_cnt_a)
`endif
    );

    parity_push_gen #(.EVEN_ODD(1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .in_data_i(in_data), .in_valid_i(in_valid),
        .in_grant_o(grant_b), .push_data_o(data_b), .push_valid_o(valid_b),
        .push_grant_i(push_grant), .tx_count_o(cnt_b)
`ifdef PARITY_ERR_INJ_EN
        , .err_inj_i(err_inj), .err_inj_count_o(err_cnt_b)
`endif
    );

    parity_push_gen #(.PARITY_BIT(1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .in_data_i(in_data), .in_valid_i(in_valid),
        .in_grant_o(grant_c), .push_data_o(data_c), .push_valid_o(valid_c),
        .push_grant_i(push_grant), .tx_count_o(cnt_c)
`ifdef PARITY_ERR_INJ_EN
        , .err_inj_i(err_inj), .err_inj_count_o(err_cnt_c)
`endif
    );

    parity_push_gen #(.CNT_WIDTH(4)) dut_c4 (
        .clk(clk), .rst_n(rst_n), .in_data_i(in_data), .in_valid_i(in_valid),
        .in_grant_o(grant_d), .push_data_o(data_d), .push_valid_o(valid_d),
        .push_grant_i(push_grant), .tx_count_o(cnt_d)
`ifdef PARITY_ERR_INJ_EN
        , .err_inj_i(err_inj), .err_inj_count_o(err_cnt_d)
`endif
    );

    // Reference encoding: even parity, parity bit at bit 0.
    function automatic logic [32:0] ref_even_lsb(input logic [31:0] d);
        int ones;
        ones = 0;
        for (int i = 0; i < 32; i++) begin
            if (d[i]) ones++;
        end
        return {d, ones[0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset between edges; grant rises on the following edge.
    task automatic do_reset();
        in_valid   = 1'b0;
        push_grant = 1'b0;
        rst_n      = 1'b0;
        #2;
        rst_n      = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        #1;
        cmp_count++;
        if (valid_a !== 1'b0 || grant_a !== 1'b0 || cnt_a !== 16'd0 || data_a !== 33'd0) begin
            fail_count++;
            $display("FAIL reset_state: valid=%b grant=%b cnt=%0d data=%h, need 0/0/0/0",
                     valid_a, grant_a, cnt_a, data_a);
        end
        tick();
        tick();
        cmp_count++;
        if (grant_a !== 1'b0) begin
            fail_count++;
            $display("FAIL reset_grant_held: grant=%b need 0", grant_a);
        end
        rst_n = 1'b1;
        #2;
        cmp_count++;
        if (grant_a !== 1'b0) begin
            fail_count++;
            $display("FAIL grant_before_edge: grant=%b need 0", grant_a);
        end
        tick();
        cmp_count++;
        if (grant_a !== 1'b1 || valid_a !== 1'b0) begin
            fail_count++;
            $display("FAIL grant_after_release: grant=%b valid=%b need 1/0", grant_a, valid_a);
        end
    endtask

    task automatic test_encoding();
        push_grant = 1'b1;
        in_valid   = 1'b1;
        in_data    = 32'h0000_0001;
        tick();
        cmp_count++;
        if (valid_a !== 1'b1 || data_a !== 33'h0_0000_0003) begin
            fail_count++;
            $display("FAIL enc_even_lsb_1: valid=%b data=%h need 1/000000003", valid_a, data_a);
        end
        cmp_count++;
        if (data_b !== 33'h0_0000_0002) begin
            fail_count++;
            $display("FAIL enc_odd_lsb_1: data=%h need 000000002", data_b);
        end
        cmp_count++;
        if (data_c !== 33'h1_0000_0001) begin
            fail_count++;
            $display("FAIL enc_even_msb_1: data=%h need 100000001", data_c);
        end
        in_data = 32'h0000_0003;
        tick();
        cmp_count++;
        if (data_a !== 33'h0_0000_0006) begin
            fail_count++;
            $display("FAIL enc_even_lsb_3: data=%h need 000000006", data_a);
        end
        cmp_count++;
        if (data_b !== 33'h0_0000_0007 || data_c !== 33'h0_0000_0003) begin
            fail_count++;
            $display("FAIL enc_variants_3: odd=%h msb=%h need 000000007/000000003", data_b, data_c);
        end
        in_valid = 1'b0;
        tick();
        cmp_count++;
        if (valid_a !== 1'b0 || data_a !== 33'h0_0000_0006 || cnt_a !== 16'd2) begin
            fail_count++;
            $display("FAIL enc_drain_hold: valid=%b data=%h cnt=%0d need 0/000000006/2",
                     valid_a, data_a, cnt_a);
        end
    endtask

    task automatic test_back_pressure();
        do_reset();
        push_grant = 1'b0;
        in_valid   = 1'b1;
        in_data    = 32'h0000_0011;
        tick();
        in_data = 32'h0000_0022;
        tick();
        in_data = 32'h0000_0007;
        cmp_count++;
        if (grant_a !== 1'b0 || valid_a !== 1'b1 || data_a !== 33'h0_0000_0022) begin
            fail_count++;
            $display("FAIL bp_full: grant=%b valid=%b data=%h need 0/1/000000022",
                     grant_a, valid_a, data_a);
        end
        tick();
        cmp_count++;
        if (grant_a !== 1'b0 || data_a !== 33'h0_0000_0022 || cnt_a !== 16'd0) begin
            fail_count++;
            $display("FAIL bp_hold: grant=%b data=%h cnt=%0d need 0/000000022/0",
                     grant_a, data_a, cnt_a);
        end
        push_grant = 1'b1;
        tick();
        cmp_count++;
        if (grant_a !== 1'b1 || valid_a !== 1'b1 || data_a !== 33'h0_0000_0044) begin
            fail_count++;
            $display("FAIL bp_second: grant=%b valid=%b data=%h need 1/1/000000044",
                     grant_a, valid_a, data_a);
        end
        tick();
        in_valid = 1'b0;
        cmp_count++;
        if (valid_a !== 1'b1 || data_a !== 33'h0_0000_000F) begin
            fail_count++;
            $display("FAIL bp_third: valid=%b data=%h need 1/00000000f", valid_a, data_a);
        end
        tick();
        cmp_count++;
        if (valid_a !== 1'b0 || cnt_a !== 16'd3) begin
            fail_count++;
            $display("FAIL bp_count: valid=%b cnt=%0d need 0/3", valid_a, cnt_a);
        end
    endtask

    task automatic test_reset_mid();
        push_grant = 1'b0;
        in_valid   = 1'b1;
        in_data    = 32'h0000_0055;
        tick();
        in_data = 32'h0000_0066;
        tick();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        cmp_count++;
        if (valid_a !== 1'b0 || grant_a !== 1'b0 || cnt_a !== 16'd0) begin
            fail_count++;
            $display("FAIL reset_mid: valid=%b grant=%b cnt=%0d need 0/0/0", valid_a, grant_a, cnt_a);
        end
        rst_n = 1'b1;
        push_grant = 1'b1;
        tick();
        cmp_count++;
        if (grant_a !== 1'b1 || valid_a !== 1'b0) begin
            fail_count++;
            $display("FAIL reset_mid_discard: grant=%b valid=%b need 1/0", grant_a, valid_a);
        end
    endtask

    // Stream n words of start, start+3, ... with both sides granted.
    task automatic stream_words(input int n, input logic [31:0] start, input string tag);
        logic [31:0] d;
        d          = start;
        push_grant = 1'b1;
        in_valid   = 1'b1;
        in_data    = d;
        for (int k = 0; k < n; k++) begin
            tick();
            cmp_count++;
            if (valid_a !== 1'b1 || grant_a !== 1'b1 || data_a !== ref_even_lsb(d)) begin
                fail_count++;
                $display("FAIL %s_word%0d: valid=%b grant=%b data=%h need 1/1/%h",
                         tag, k, valid_a, grant_a, data_a, ref_even_lsb(d));
            end
            d       = d + 32'd3;
            in_data = d;
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_streaming();
        do_reset();
        stream_words(30, 32'h0000_0100, "stream");
        cmp_count++;
        if (valid_a !== 1'b0 || cnt_a !== 16'd30) begin
            fail_count++;
            $display("FAIL stream_count: valid=%b cnt=%0d need 0/30", valid_a, cnt_a);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        stream_words(17, 32'hFFFF_FFF0, "wrap");
        cmp_count++;
        if (cnt_d !== 4'd1 || cnt_a !== 16'd17) begin
            fail_count++;
            $display("FAIL counter_wrap: cnt4=%0d cnt16=%0d need 1/17", cnt_d, cnt_a);
        end
    endtask

`ifdef PARITY_ERR_INJ_EN
    task automatic test_err_inj();
        do_reset();
        push_grant = 1'b1;
        in_valid   = 1'b1;
        err_inj    = 1'b1;
        in_data    = 32'h0000_0001;
        tick();
        err_inj = 1'b0;
        cmp_count++;
        if (data_a !== 33'h0_0000_0002 || err_cnt_a !== 16'd1) begin
            fail_count++;
            $display("FAIL err_inj_word: data=%h errcnt=%0d need 000000002/1", data_a, err_cnt_a);
        end
        tick();
        in_valid = 1'b0;
        cmp_count++;
        if (data_a !== 33'h0_0000_0003 || err_cnt_a !== 16'd1) begin
            fail_count++;
            $display("FAIL err_inj_clean: data=%h errcnt=%0d need 000000003/1", data_a, err_cnt_a);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_encoding();
        test_back_pressure();
        test_reset_mid();
        test_streaming();
        test_wrap();
`ifdef PARITY_ERR_INJ_EN
        test_err_inj();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule
